// File: rtl/axis_bram_frame_writer.sv
// Streams one frame of AXI-Stream beats into consecutive BRAM words, then raises a done flag.
// Optional AXIS_BRAM_FRAME_WRITER_TLAST_EN: s_axis_tlast also terminates the frame early.
module axis_bram_frame_writer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         start,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_data,
  output logic [BRAM_ADDR_WIDTH:0]     sts_data,
  output logic                         s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         m_axis_done_tvalid,
  input  logic                         m_axis_done_tready,
  output logic                         bram_porta_clk,
  output logic                         bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we,
  output logic [1:0]                   dbg_state
);

`ifdef AXIS_BRAM_FRAME_WRITER_TLAST_EN
  localparam logic TLAST_EN = 1'b1;
`else
  localparam logic TLAST_EN = 1'b0;
`endif

  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [BRAM_ADDR_WIDTH:0]   STS_ONE  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                       state, state_nxt;
  logic [BRAM_ADDR_WIDTH-1:0]   addr_reg;
  logic [BRAM_ADDR_WIDTH-1:0]   last_reg;
  logic [BRAM_ADDR_WIDTH:0]     sts_reg;
  logic                         beat_ok;
  logic                         beat_final;

  // Handshake: a beat transfers on any rising edge where s_axis_tvalid and
  // s_axis_tready are both high; done transfers when done_tvalid and done_tready are high.
  assign beat_ok    = (state == ST_FILL) && s_axis_tvalid;
  assign beat_final = beat_ok && ((addr_reg == last_reg) || (TLAST_EN && s_axis_tlast));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)              state_nxt = ST_FILL;
      ST_FILL: if (beat_final)         state_nxt = ST_DONE;
      ST_DONE: if (m_axis_done_tready) state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready      = 1'b0;
    m_axis_done_tvalid = 1'b0;
    bram_porta_we      = '0;
    case (state)
      ST_FILL: begin
        s_axis_tready = 1'b1;
        if (beat_ok) bram_porta_we = '1;
      end
      ST_DONE: m_axis_done_tvalid = 1'b1;
      default: ;
    endcase
  end

  // The final beat leaves addr_reg on last_reg so a full 2^A frame never wraps to 0.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_reg <= '0;
      last_reg <= '0;
      sts_reg  <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        last_reg <= cfg_data;
        addr_reg <= '0;
        sts_reg  <= '0;
      end
    end else if (beat_ok) begin
      sts_reg <= sts_reg + STS_ONE;
      if (!beat_final) addr_reg <= addr_reg + ADDR_ONE;
    end
  end

  assign sts_data          = sts_reg;
  assign bram_porta_clk    = aclk;
  assign bram_porta_rst    = ~aresetn;
  assign bram_porta_addr   = addr_reg;
  assign bram_porta_wrdata = s_axis_tdata;
  assign dbg_state         = state;

endmodule
